// File: rtl/seg7_char_pkg.sv
// Shared constants and state type for the 2-bit character 7-segment reader.
// Segment patterns are active-low, index 0 = segment a ... 6 = segment g.
package seg7_char_pkg;

  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] CH_D     = 2'b00;
  localparam logic [1:0] CH_E     = 2'b01;
  localparam logic [1:0] CH_1     = 2'b10;
  localparam logic [1:0] CH_BLANK = 2'b11;

  localparam logic [1:0] ROT_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DECODE,
    VALID
  } state_t;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational decode of one active-low 7-segment pattern back to its 2-bit code.
// Unknown patterns report code 11 with legal low.
module seg7_char_decode
  import seg7_char_pkg::*;
(
  input  logic [0:6] seg,
  output logic [1:0] code,
  output logic       legal
);

  always_comb begin
    code  = CH_BLANK;
    legal = 1'b1;
    case (seg)
      SEG_D:     code = CH_D;
      SEG_E:     code = CH_E;
      SEG_1:     code = CH_1;
      SEG_BLANK: code = CH_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_char_reader.sv
// Samples three 7-segment buses, waits for them to settle, decodes each digit and
// reports which rotation of the reference word is displayed.
module seg7_char_reader
  import seg7_char_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Sample,
  input  logic [0:6] HEXL,
  input  logic [0:6] HEXM,
  input  logic [0:6] HEXR,
  input  logic [5:0] RefWord,
  output logic       Ready,
  output logic       Valid,
  input  logic       Ack,
  output logic [1:0] CharL,
  output logic [1:0] CharM,
  output logic [1:0] CharR,
  output logic [1:0] Rot,
  output logic       Err,
  output logic       Timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nx;
  logic [0:6]      shadow_l, shadow_m, shadow_r;
  logic [CW-1:0]   stable_cnt, to_cnt;
  logic [1:0]      code_l, code_m, code_r;
  logic            legal_l, legal_m, legal_r;
  logic            same, settled, timed_out, all_legal;
  logic [1:0]      rot_sel;

  seg7_char_decode u_dec_l (.seg(shadow_l), .code(code_l), .legal(legal_l));
  seg7_char_decode u_dec_m (.seg(shadow_m), .code(code_m), .legal(legal_m));
  seg7_char_decode u_dec_r (.seg(shadow_r), .code(code_r), .legal(legal_r));

  assign same      = ({HEXL, HEXM, HEXR} == {shadow_l, shadow_m, shadow_r});
  assign settled   = same && (stable_cnt == STABLE_LAST);
  assign timed_out = !settled && (to_cnt == TIMEOUT_LAST);
  assign all_legal = legal_l && legal_m && legal_r;

  assign Ready = (state == IDLE);
  assign Valid = (state == VALID);

  // Lowest matching rotation wins; any illegal digit forces no-match.
  always_comb begin
    rot_sel = ROT_NONE;
    if (all_legal) begin
      if ({code_l, code_m, code_r} == {RefWord[5:4], RefWord[3:2], RefWord[1:0]})
        rot_sel = 2'd0;
      else if ({code_l, code_m, code_r} == {RefWord[3:2], RefWord[1:0], RefWord[5:4]})
        rot_sel = 2'd1;
      else if ({code_l, code_m, code_r} == {RefWord[1:0], RefWord[5:4], RefWord[3:2]})
        rot_sel = 2'd2;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Sample) state_nx = SETTLE;
      SETTLE: begin
        if (settled)        state_nx = DECODE;
        else if (timed_out) state_nx = VALID;
      end
      DECODE:  state_nx = VALID;
      VALID:   if (Ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Results are only touched on DECODE or timeout, so they persist through IDLE.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      shadow_l   <= SEG_BLANK;
      shadow_m   <= SEG_BLANK;
      shadow_r   <= SEG_BLANK;
      stable_cnt <= '0;
      to_cnt     <= '0;
      CharL      <= CH_BLANK;
      CharM      <= CH_BLANK;
      CharR      <= CH_BLANK;
      Rot        <= ROT_NONE;
      Err        <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Sample) begin
            shadow_l   <= HEXL;
            shadow_m   <= HEXM;
            shadow_r   <= HEXR;
            stable_cnt <= '0;
            to_cnt     <= '0;
          end
        end
        SETTLE: begin
          if (to_cnt != TIMEOUT_LAST) to_cnt <= to_cnt + 1'b1;
          if (same) begin
            if (stable_cnt != STABLE_LAST) stable_cnt <= stable_cnt + 1'b1;
          end else begin
            shadow_l   <= HEXL;
            shadow_m   <= HEXM;
            shadow_r   <= HEXR;
            stable_cnt <= '0;
          end
          if (timed_out) begin
            CharL   <= CH_BLANK;
            CharM   <= CH_BLANK;
            CharR   <= CH_BLANK;
            Rot     <= ROT_NONE;
            Err     <= 1'b1;
            Timeout <= 1'b1;
          end
        end
        DECODE: begin
          CharL   <= code_l;
          CharM   <= code_m;
          CharR   <= code_r;
          Rot     <= rot_sel;
          Err     <= !all_legal;
          Timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_char_reader.sv
// Randomized directed bench for seg7_char_reader, checked against a window-based
// behavioural model of settle, decode, rotation match and timeout.
module tb_seg7_char_reader;

  localparam int STAB    = 4;
  localparam int TMO_A   = 255;
  localparam int TMO_T   = 16;
  localparam int BUDGET  = 300;

  localparam logic [0:6] P_D     = 7'b1000010;
  localparam logic [0:6] P_E     = 7'b0110000;
  localparam logic [0:6] P_1     = 7'b1001111;
  localparam logic [0:6] P_BLANK = 7'b1111111;

  logic       clock;
  logic       resetn;
  logic       smp, ack;
  bit         sel;
  logic [0:6] hexl, hexm, hexr;
  logic [5:0] ref_word;

  logic       sample_a, sample_t, ack_a, ack_t;
  logic       a_ready, a_valid, a_err, a_to;
  logic [1:0] a_cl, a_cm, a_cr, a_rot;
  logic       t_ready, t_valid, t_err, t_to;
  logic [1:0] t_cl, t_cm, t_cr, t_rot;

  logic        o_ready;
  logic [10:0] obs_vec;
  logic [10:0] exp_vec;

  int checks = 0;
  int errors = 0;
  logic [20:0] seq[$];

  assign sample_a = smp & ~sel;
  assign sample_t = smp & sel;
  assign ack_a    = ack & ~sel;
  assign ack_t    = ack & sel;
  assign o_ready  = sel ? t_ready : a_ready;
  assign obs_vec  = sel ? {t_valid, t_cl, t_cm, t_cr, t_rot, t_err, t_to}
                        : {a_valid, a_cl, a_cm, a_cr, a_rot, a_err, a_to};

  seg7_char_reader #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TMO_A)) dut_a (
    .Clock(clock), .Resetn(resetn), .Sample(sample_a),
    .HEXL(hexl), .HEXM(hexm), .HEXR(hexr), .RefWord(ref_word),
    .Ready(a_ready), .Valid(a_valid), .Ack(ack_a),
    .CharL(a_cl), .CharM(a_cm), .CharR(a_cr), .Rot(a_rot),
    .Err(a_err), .Timeout(a_to)
  );

  seg7_char_reader #(.STABLE_CYCLES(STAB), .TIMEOUT_CYCLES(TMO_T)) dut_t (
    .Clock(clock), .Resetn(resetn), .Sample(sample_t),
    .HEXL(hexl), .HEXM(hexm), .HEXR(hexr), .RefWord(ref_word),
    .Ready(t_ready), .Valid(t_valid), .Ack(ack_t),
    .CharL(t_cl), .CharM(t_cm), .CharR(t_cr), .Rot(t_rot),
    .Err(t_err), .Timeout(t_to)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [0:6] pat_of(int c);
    case (c)
      0:       return P_D;
      1:       return P_E;
      2:       return P_1;
      default: return P_BLANK;
    endcase
  endfunction

  // Returns {legal, code}.
  function automatic logic [2:0] char_of(logic [0:6] p);
    if (p == P_D)     return 3'b100;
    if (p == P_E)     return 3'b101;
    if (p == P_1)     return 3'b110;
    if (p == P_BLANK) return 3'b111;
    return 3'b011;
  endfunction

  // Rotation r shows reference character (i + r) mod 3 at position i.
  function automatic logic [1:0] model_rot(logic [1:0] l, logic [1:0] m, logic [1:0] r,
                                           logic [5:0] w);
    logic [1:0] shown[3];
    logic [1:0] refc[3];
    bit ok;
    shown = '{l, m, r};
    refc  = '{w[5:4], w[3:2], w[1:0]};
    for (int rr = 0; rr < 3; rr++) begin
      ok = 1'b1;
      for (int i = 0; i < 3; i++)
        if (shown[i] != refc[(i + rr) % 3]) ok = 1'b0;
      if (ok) return 2'(rr);
    end
    return 2'b11;
  endfunction

  function automatic logic [20:0] seq_at(int k);
    if (k < seq.size()) return seq[k];
    return seq[seq.size() - 1];
  endfunction

  // Decode happens at the first edge k whose input equals the previous STAB inputs;
  // otherwise the timeout fires at edge tmo. Returns the edge at which Valid is seen.
  function automatic int model_valid_edge(int tmo, output int dec);
    bit steady;
    for (int k = STAB; k <= tmo; k++) begin
      steady = 1'b1;
      for (int j = 1; j <= STAB; j++)
        if (seq_at(k - j) != seq_at(k)) steady = 1'b0;
      if (steady) begin
        dec = k;
        return k + 1;
      end
    end
    dec = -1;
    return tmo;
  endfunction

  function automatic logic [20:0] word_of(int l, int m, int r);
    return {pat_of(l), pat_of(m), pat_of(r)};
  endfunction

  task automatic drive(logic [20:0] v);
    hexl = v[20:14];
    hexm = v[13:7];
    hexr = v[6:0];
  endtask

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Runs one transaction from seq on the selected DUT and leaves it in VALID.
  task automatic applyStimulus(string tag, bit poke);
    int got, want, dec;
    logic [20:0] v;
    logic [2:0]  cl, cm, cr;
    logic        err;
    logic [1:0]  rot;
    @(negedge clock);
    checkOutput({tag, "_ready_idle"}, o_ready, 1);
    drive(seq_at(0));
    smp = 1'b1;
    @(posedge clock);
    #1;
    smp = 1'b0;
    drive(seq_at(1));
    checkOutput({tag, "_ready_drop"}, o_ready, 0);
    got = -1;
    for (int e = 1; e <= BUDGET; e++) begin
      @(posedge clock);
      #1;
      if (obs_vec[10] === 1'b1) begin
        got = e;
        break;
      end
      drive(seq_at(e + 1));
      smp = poke ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    smp = 1'b0;
    want = model_valid_edge(sel ? TMO_T : TMO_A, dec);
    if (dec < 0) begin
      exp_vec = {1'b1, 2'b11, 2'b11, 2'b11, 2'b11, 1'b1, 1'b1};
    end else begin
      v   = seq_at(dec);
      cl  = char_of(v[20:14]);
      cm  = char_of(v[13:7]);
      cr  = char_of(v[6:0]);
      err = !(cl[2] && cm[2] && cr[2]);
      rot = err ? 2'b11 : model_rot(cl[1:0], cm[1:0], cr[1:0], ref_word);
      exp_vec = {1'b1, cl[1:0], cm[1:0], cr[1:0], rot, err, 1'b0};
    end
    checkOutput({tag, "_latency"}, got, want);
    checkOutput({tag, "_result"}, obs_vec, exp_vec);
  endtask

  task automatic ackResult(string tag);
    @(negedge clock);
    ack = 1'b1;
    @(posedge clock);
    #1;
    ack = 1'b0;
    exp_vec[10] = 1'b0;
    checkOutput({tag, "_ack_ready"}, o_ready, 1);
    checkOutput({tag, "_ack_hold"}, obs_vec, exp_vec);
  endtask

  task automatic checkResetState(string tag);
    checkOutput({tag, "_ready"}, o_ready, 1);
    checkOutput({tag, "_outs"}, obs_vec, {1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 1'b0, 1'b0});
  endtask

  initial begin
    int sh[3];
    int rc[3];
    logic [20:0] fin;

    resetn   = 1'b0;
    smp      = 1'b0;
    ack      = 1'b0;
    sel      = 1'b0;
    ref_word = 6'b00_01_10;
    drive(word_of(3, 3, 3));
    repeat (2) @(posedge clock);
    #1;
    checkResetState("por_a");
    sel = 1'b1;
    #1;
    checkResetState("por_t");
    sel = 1'b0;
    resetn = 1'b1;

    // Steady d,E,1 against reference d,E,1.
    seq = '{word_of(0, 1, 2)};
    applyStimulus("rot0", 1'b0);
    ackResult("rot0");

    // Other rotations, no-match, and a long hold without Ack.
    seq = '{word_of(1, 2, 0)};
    applyStimulus("rot1", 1'b0);
    ackResult("rot1");
    seq = '{word_of(2, 0, 1)};
    applyStimulus("rot2", 1'b0);
    ackResult("rot2");
    seq = '{word_of(0, 0, 0)};
    applyStimulus("nomatch", 1'b0);
    repeat (10) begin
      @(posedge clock);
      #1;
      checkOutput("hold_no_ack", obs_vec, exp_vec);
    end
    ackResult("nomatch");

    // HEXR toggling every 2 cycles for 20 cycles, then holding.
    seq = {};
    for (int k = 0; k < 20; k++) seq.push_back(word_of(0, 1, ((k / 2) % 2 == 1) ? 1 : 2));
    seq.push_back(word_of(0, 1, 3));
    applyStimulus("toggle_r", 1'b0);
    ackResult("toggle_r");

    // Illegal middle digit with stray Sample pulses in SETTLE and VALID.
    seq = '{{P_D, 7'b0000000, P_1}};
    applyStimulus("illegal", 1'b1);
    @(negedge clock);
    smp = 1'b1;
    @(posedge clock);
    #1;
    smp = 1'b0;
    checkOutput("sample_in_valid", obs_vec, exp_vec);
    ackResult("illegal");
    repeat (6) begin
      @(posedge clock);
      #1;
      checkOutput("no_second_result", obs_vec[10], 0);
    end

    // Settle timeout on the short-timeout instance: HEXL toggles every cycle.
    sel = 1'b1;
    seq = {};
    for (int k = 0; k < 40; k++) seq.push_back(word_of(k % 2, 1, 2));
    applyStimulus("timeout", 1'b0);
    ackResult("timeout");
    sel = 1'b0;

    // Randomized transactions: rotations of a random word, random chars, noise, illegals.
    for (int t = 0; t < 8; t++) begin
      ref_word = 6'($urandom);
      rc = '{ref_word[5:4], ref_word[3:2], ref_word[1:0]};
      case ($urandom_range(0, 3))
        0: sh = '{rc[0], rc[1], rc[2]};
        1: sh = '{rc[1], rc[2], rc[0]};
        2: sh = '{rc[2], rc[0], rc[1]};
        default: sh = '{$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)};
      endcase
      fin = word_of(sh[0], sh[1], sh[2]);
      if ($urandom_range(0, 3) == 0) fin[13:7] = 7'($urandom);
      seq = {};
      repeat ($urandom_range(0, 8))
        seq.push_back(word_of($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)));
      seq.push_back(fin);
      applyStimulus("random", 1'b0);
      ackResult("random");
    end

    // Reset mid-SETTLE after a non-blank result, then a clean transaction.
    ref_word = 6'b00_01_10;
    seq = '{word_of(0, 1, 2)};
    applyStimulus("pre_reset", 1'b0);
    ackResult("pre_reset");
    @(negedge clock);
    smp = 1'b1;
    @(posedge clock);
    #1;
    smp = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    checkResetState("rst_settle");
    seq = '{word_of(1, 2, 0)};
    applyStimulus("after_rst", 1'b0);

    // Reset while holding a result in VALID.
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    checkResetState("rst_valid");
    seq = '{word_of(2, 0, 1)};
    applyStimulus("final", 1'b0);
    ackResult("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
